pc_next_unit: RTL

- Fetch-stage program counter for the pipelined CPU.
- Consumes the word-aligned branch offset produced by the left-shift-by-2 stage, adds it to the branch's PC+4, and selects the next PC among sequential, branch and jump targets.
- Holds the PC register, handles stall and redirect, and drives squash signals to the IF/ID and ID/EX pipeline registers.

---
 rtl/pc_next_unit.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/pc_next_unit.sv
// ---------------------------------------------------------------------------
// pc_next_unit
//
// Fetch-stage program counter for the pipelined CPU. Holds the PC register,
// computes the sequential, branch and jump targets, selects the next PC with
// the priority rst > branch > jump > stall > sequential, and drives the
// squash signals for the IF/ID and ID/EX pipeline registers.
//
// Optional feature (compile-time macro PC_REDIRECT_COUNT_EN):
//   adds output redirect_count, a wrapping count of accepted redirects.
//
// Parameters:
//   RESET_PC           PC loaded on reset (word-aligned)
//
// Ports:
//   clk                rising-edge clock
//   rst                synchronous, active-high reset
//   stall              hazard-unit hold; PC keeps its value
//   branch_taken       branch in EX resolved taken
//   branch_pc_plus4    PC+4 of the branch instruction in EX
//   branch_offset_sl2  sign-extended branch offset, already shifted left by 2
//   jump               J-type jump decoded in ID
//   jump_pc_plus4      PC+4 of the jump in ID (only bits [31:28] are used)
//   jump_index         26-bit instruction index of the jump
//   pc                 current fetch address (registered)
//   pc_plus4           pc + 4 (combinational)
//   if_valid           fetched instruction is valid (registered)
//   flush_if_id        squash IF/ID on the next edge (combinational)
//   flush_id_ex        squash ID/EX on the next edge (combinational)
//   redirect_count     accepted-redirect counter (PC_REDIRECT_COUNT_EN only)
// ---------------------------------------------------------------------------
module pc_next_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_pc_plus4,
   input  logic [31:0] branch_offset_sl2,
   input  logic        jump,
   input  logic [31:0] jump_pc_plus4,
   input  logic [25:0] jump_index,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        if_valid,
   output logic        flush_if_id,
   output logic        flush_id_ex
`ifdef PC_REDIRECT_COUNT_EN
   ,
   output logic [31:0] redirect_count
`endif
);

   localparam int unsigned PC_W    = 32;
   localparam int unsigned STATE_W = 2;

   // Fetch state encoding
   localparam logic [STATE_W-1:0] ST_BOOT  = 2'd0;
   localparam logic [STATE_W-1:0] ST_RUN   = 2'd1;
   localparam logic [STATE_W-1:0] ST_REDIR = 2'd2;

   logic [STATE_W-1:0] state;
   logic [STATE_W-1:0] state_nxt;
   logic [PC_W-1:0]    pc_nxt;
   logic [PC_W-1:0]    branch_target;
   logic [PC_W-1:0]    jump_target;
   logic               branch_acc;
   logic               jump_acc;
   logic               if_valid_nxt;

   // Only the region bits of the jump's PC+4 feed the target
   logic               unused_jump_pc_low;
   assign unused_jump_pc_low = ^jump_pc_plus4[27:0];

   // Target arithmetic, all modulo 2^32
   assign pc_plus4      = pc + PC_W'(4);
   assign branch_target = branch_pc_plus4 + branch_offset_sl2;
   assign jump_target   = {jump_pc_plus4[31:28], jump_index, 2'b00};

   // Next-state / next-PC selection
   always_comb begin
      state_nxt  = state;
      pc_nxt     = pc;
      branch_acc = 1'b0;
      jump_acc   = 1'b0;

      case (state)
         ST_BOOT: begin
            // First fetch slot after reset: redirects are ignored, PC holds
            state_nxt = ST_RUN;
         end
         ST_RUN, ST_REDIR: begin
            if (branch_taken) begin
               branch_acc = 1'b1;
               pc_nxt     = branch_target;
               state_nxt  = ST_REDIR;
            end else if (jump && (state == ST_RUN)) begin
               // In REDIR the jump in ID is wrong-path and is dropped
               jump_acc  = 1'b1;
               pc_nxt    = jump_target;
               state_nxt = ST_REDIR;
            end else begin
               state_nxt = ST_RUN;
               if (!stall) begin
                  pc_nxt = pc_plus4;
               end
            end
         end
         default: begin
            state_nxt = ST_BOOT;
         end
      endcase

      // Reset overrides any pending redirect on the same edge
      if (rst) begin
         state_nxt  = ST_BOOT;
         pc_nxt     = RESET_PC;
         branch_acc = 1'b0;
         jump_acc   = 1'b0;
      end
   end

   assign if_valid_nxt = (state_nxt != ST_BOOT);

   // Squashes fire in the same cycle as the accepted redirect
   assign flush_if_id = branch_acc | jump_acc;
   assign flush_id_ex = branch_acc;

   // State and PC registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_BOOT;
         pc       <= RESET_PC;
         if_valid <= 1'b0;
      end else begin
         state    <= state_nxt;
         pc       <= pc_nxt;
         if_valid <= if_valid_nxt;
      end
   end

`ifdef PC_REDIRECT_COUNT_EN
   // One count per accepted redirect; a dropped jump adds nothing
   always_ff @(posedge clk) begin
      if (rst) begin
         redirect_count <= '0;
      end else if (flush_if_id) begin
         redirect_count <= redirect_count + PC_W'(1);
      end
   end
`endif

endmodule
